// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants and types for the 8-way round-robin mux scheduler.
package mux8_sched_pkg;

   localparam int NREQ         = 8;
   localparam int SEL_W        = 3;
   localparam int DEF_MAX_HOLD = 4;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] i);
      onehot8 = NREQ'(1) << i;
   endfunction

endpackage

// File: rtl/mux8_rr_sched_if.sv
// Request/grant bundle between the requesters (master) and the scheduler (slave).
interface mux8_rr_sched_if #(
   parameter int CNT_W = 4
);
   import mux8_sched_pkg::*;

   logic [NREQ-1:0]  req;
   logic             done;
   logic [NREQ-1:0]  grant;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic [CNT_W-1:0] hold_cnt;

   modport master (output req, done, input grant, sel, busy, hold_cnt);
   modport slave  (input req, done, output grant, sel, busy, hold_cnt);

endinterface

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Combinational round-robin pick: first set bit of (req & ~mask) scanning up from start, wrapping.
module rr_pick8
   import mux8_sched_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  mask,
   input  logic [SEL_W-1:0] start,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [NREQ-1:0]  eff;
   logic [NREQ-1:0]  rot;
   logic [SEL_W-1:0] pos;

   assign eff = req & ~mask;

   // rot[0] is the candidate at 'start', so a plain lowest-bit encoder gives the RR order
   for (genvar i = 0; i < NREQ; i++) begin : g_rot
      logic [SEL_W-1:0] src;
      assign src    = start + SEL_W'(i);
      assign rot[i] = eff[src];
   end

   always_comb begin
      pos = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) pos = SEL_W'(i);
      end
   end

   assign found = |rot;
   assign idx   = pos + start;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin owner scheduler for a shared 8:1 mux path with a per-grant hold limit.
module mux8_rr_sched
   import mux8_sched_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   mux8_rr_sched_if.slave  bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [SEL_W-1:0] sel_q,   sel_d;
   logic [SEL_W-1:0] ptr_q,   ptr_d;
   logic             busy_q,  busy_d;
   logic [CNT_W-1:0] hold_q,  hold_d;

   logic             own;
   logic             rel;
   logic [NREQ-1:0]  pick_mask;
   logic [SEL_W-1:0] pick_start;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;

   // One picker serves both the idle pick and the handover pick; on handover the
   // old owner is masked so it cannot win the same cycle it lets go.
   assign own        = (state_q == OWN);
   assign pick_mask  = own ? onehot8(sel_q) : '0;
   assign pick_start = own ? (sel_q + SEL_W'(1)) : ptr_q;
   assign rel        = bus.done | ~bus.req[sel_q] | (hold_q == HOLD_LAST);

   rr_pick8 u_pick (
      .req   (bus.req),
      .mask  (pick_mask),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = OWN;
               grant_d = onehot8(pick_idx);
               sel_d   = pick_idx;
               busy_d  = 1'b1;
               hold_d  = '0;
            end
         end
         OWN: begin
            if (!rel) begin
               hold_d = hold_q + CNT_W'(1);
            end else begin
               ptr_d  = sel_q + SEL_W'(1);
               hold_d = '0;
               if (pick_found) begin
                  grant_d = onehot8(pick_idx);
                  sel_d   = pick_idx;
               end else begin
                  // sel is left alone in IDLE so the mux select does not toggle
                  state_d = IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.sel      = sel_q;
   assign bus.busy     = busy_q;
   assign bus.hold_cnt = hold_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench: directed vectors push expected outputs, a monitor pops and compares after each edge.
module tb_mux8_rr_sched;
   import mux8_sched_pkg::*;

   localparam int MH    = 4;
   localparam int CW    = 4;
   localparam int BOUND = 8 * MH + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux8_rr_sched_if #(.CNT_W(CW)) bus ();

   mux8_rr_sched #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]    g;
      logic [2:0]    s;
      logic          b;
      logic [CW-1:0] h;
      string         tag;
   } exp_t;

   exp_t sb[$];
   int   tests   = 0;
   int   fails   = 0;
   bit   rand_on = 1'b0;
   int   waitc[8];

   task automatic step(input logic [7:0] r, input logic d, input logic [7:0] g,
                       input logic [2:0] s, input logic b, input int h, input string tag);
      exp_t e;
      @(negedge clk);
      bus.req  = r;
      bus.done = d;
      e.g = g; e.s = s; e.b = b; e.h = CW'(h); e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      tests++;
      if (bus.grant !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0 || bus.hold_cnt !== '0) begin
         fails++;
         $display("FAIL %s: grant=%h sel=%0d busy=%0b hold=%0d, required all zero",
                  tag, bus.grant, bus.sel, bus.busy, bus.hold_cnt);
      end
   endtask

   // Monitor: scoreboard compare plus invariants and starvation bound
   always @(posedge clk) begin
      exp_t e;
      logic ok;
      #1;
      if (rst_n) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (bus.grant !== e.g || bus.sel !== e.s || bus.busy !== e.b || bus.hold_cnt !== e.h) begin
               fails++;
               $display("FAIL %s: grant=%h sel=%0d busy=%0b hold=%0d, required grant=%h sel=%0d busy=%0b hold=%0d",
                        e.tag, bus.grant, bus.sel, bus.busy, bus.hold_cnt, e.g, e.s, e.b, e.h);
            end
         end
         ok = 1'b1;
         if ((bus.grant & (bus.grant - 8'd1)) != 8'h00) ok = 1'b0;
         if (bus.busy !== (bus.grant != 8'h00)) ok = 1'b0;
         if (bus.busy && !bus.grant[bus.sel]) ok = 1'b0;
         if (bus.hold_cnt > CW'(MH - 1)) ok = 1'b0;
         if (rand_on) begin
            for (int k = 0; k < 8; k++) begin
               if (bus.req[k] && !bus.grant[k]) waitc[k]++;
               else waitc[k] = 0;
               if (waitc[k] > BOUND) begin
                  ok = 1'b0;
                  waitc[k] = 0;
               end
            end
         end
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL invariant: grant=%h sel=%0d busy=%0b hold=%0d req=%h, required onehot0 grant, grant[sel] when busy, hold<=%0d, no wait>%0d",
                     bus.grant, bus.sel, bus.busy, bus.hold_cnt, bus.req, MH - 1, BOUND);
         end
      end
   end

   initial begin
      bus.req  = 8'h00;
      bus.done = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 0, "idle_no_req");

      // single requester 2: four-cycle tenure, one idle cycle, re-grant
      for (int r = 0; r < 2; r++) begin
         for (int h = 0; h < MH; h++) step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, h, "single_hold");
         step(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 0, "single_gap");
      end
      step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 0, "pre_async_grant");

      // reset mid-grant must clear outputs before the next edge
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      bus.req = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;

      // all requesting: 0..7 then 0, four cycles each, no bubbles
      for (int o = 0; o < 9; o++)
         for (int h = 0; h < MH; h++)
            step(8'hFF, 1'b0, 8'h01 << (o % 8), 3'(o % 8), 1'b1, h, "all_rr");

      // wrap-around between 7 and 0 with done pulses
      step(8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 0, "wrap_to7");
      step(8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 0, "done7_to0");
      step(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1, "own0_hold");
      step(8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 0, "done0_to7");
      step(8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1, "own7_hold");

      // req drop handover, then done coinciding with the hold limit
      step(8'h18, 1'b0, 8'h08, 3'd3, 1'b1, 0, "drop7_to3");
      step(8'h18, 1'b0, 8'h08, 3'd3, 1'b1, 1, "own3_hold");
      step(8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 0, "drop3_to4");
      step(8'h18, 1'b0, 8'h10, 3'd4, 1'b1, 1, "own4_h1");
      step(8'h18, 1'b0, 8'h10, 3'd4, 1'b1, 2, "own4_h2");
      step(8'h18, 1'b0, 8'h10, 3'd4, 1'b1, 3, "own4_h3");
      step(8'h18, 1'b1, 8'h08, 3'd3, 1'b1, 0, "done_at_limit");
      step(8'h18, 1'b0, 8'h08, 3'd3, 1'b1, 1, "single_handover");
      step(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 0, "release_idle_sel_kept");

      // randomized sticky requests with occasional done
      @(negedge clk);
      for (int k = 0; k < 8; k++) waitc[k] = 0;
      rand_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int k = 0; k < 8; k++)
            if ($urandom_range(15) == 0) bus.req[k] = ~bus.req[k];
         bus.done = ($urandom_range(7) == 0);
      end
      @(negedge clk);
      rand_on  = 1'b0;
      bus.req  = 8'h00;
      bus.done = 1'b0;
      repeat (2) @(negedge clk);

      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
